bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter that shares one 8-bit bus among N requesters. It serialises ownership with a bounded hold time, an optional lock, and a one-cycle turnaround between owners. It sits between requesting blocks and the shared bus net, and replaces ad-hoc multiple continuous drivers with a single arbitrated driver.

## Interface

Parameters:
- `N`, 4: number of requesters, 2..8.
- `W`, 8: bus data width.
- `MAX_HOLD`, 16: grant cycles after which a non-locked owner may be preempted, ≥1.

Ports:
- `clk`  input  1  sole clock; all state updates on posedge.
- `rst`  input  1  reset, synchronous and active-high.
- `req`  input  N  request per requester; level, held while ownership is wanted.
- `lock`  input  N  per-requester preemption inhibit; only the owner's bit is used.
- `data_in`  input  N*W  per-requester data; slice i is `[i*W +: W]`.
- `gnt`  output  N  one-hot grant, registered.
- `gnt_id`  output  clog2(N)  index of the owner; 0 when idle.
- `bus_out`  output  W  `data_in` slice of the owner; 0 when no grant.
- `bus_valid`  output  1  equals `|gnt`.
- `timeout`  output  1  one-cycle pulse when an owner was preempted.

## Operation

- State register values: IDLE, OWN, TURN. Registers `last` (clog2(N)) and `hold_cnt` (clog2(MAX_HOLD+1)).
- Pick rule: search `req` starting at `(last+1) mod N`, ascending with wrap. The first set bit wins. The last owner therefore has lowest priority.
- IDLE:
  - any `req` → OWN with winner: `gnt` ← onehot(winner), `last` ← winner, `hold_cnt` ← 1.
  - otherwise stay in IDLE.
- OWN, evaluated at each edge:
  - `req[owner]`=0 → TURN (release), `timeout` stays 0.
  - `hold_cnt`==MAX_HOLD and `lock[owner]`=0 and any other `req` set → TURN (preempt), `timeout` ← 1.
  - otherwise stay in OWN, `hold_cnt` ← min(`hold_cnt`+1, MAX_HOLD) (saturating).
- On entry to TURN, `gnt` ← 0.
- TURN lasts exactly one cycle with no grant. At its end:
  - any `req` → OWN using the pick rule, same updates as from IDLE;
  - otherwise → IDLE.
- `timeout` is 1 only in the TURN cycle that follows a preempt.
- `bus_out` and `bus_valid` are combinational from registered `gnt` and live `data_in`. There is no extra register stage.
- `lock` sampled while the owner is not at MAX_HOLD has no effect. Non-owner `lock` bits are ignored.
- A preempted requester that keeps `req` high re-enters arbitration normally, at lowest priority.

## Timing

- Reset, sampled at a posedge, sets on the next cycle: state=IDLE, `gnt`=0, `gnt_id`=0, `bus_out`=0, `bus_valid`=0, `timeout`=0, `last`=N-1 (so requester 0 wins first), `hold_cnt`=0.
- Reset mid-OWN aborts the grant with no TURN cycle and no timeout pulse.
- Request-to-grant latency: `req` high before edge k gives `gnt` high after edge k, provided the state at edge k is IDLE or TURN.
- Owner handoff: exactly one no-grant cycle between consecutive owners.
- Grant cycle counts:
  - an unlocked owner with competition holds exactly MAX_HOLD cycles;
  - without competition it holds indefinitely.
- Release and new request on the same edge: the release wins, and the new request is arbitrated at the end of TURN.
- `hold_cnt` never wraps; it saturates at MAX_HOLD.

## Structure

- Shared header `bus_arb_defs.vh`: state encodings (`BA_IDLE`=0, `BA_OWN`=1, `BA_TURN`=2) and the default `MAX_HOLD`.
- One sub-module, `rr_pick`: combinational round-robin picker with inputs `req[N]` and `last`, outputs `any` and `winner`. It is reused by other arbiters.
- `bus_arbiter` holds the FSM, counter, `last` register and the output mux.

## Test plan

- Reset:
  - hold `rst` for 2 cycles with `req`=4'b1111 → `gnt`=0, `bus_valid`=0, `bus_out`=8'h00, `timeout`=0.
  - release `rst` → `gnt`=4'b0001 one cycle later.
- Single requester: `req`=4'b0100, `data_in[2]`=8'hA5.
  - → `gnt`=4'b0100, `gnt_id`=2, `bus_out`=8'hA5 one cycle after `req`.
  - drop `req` → `gnt`=0 on the next cycle, then IDLE.
- Rotation: MAX_HOLD=4, `req`=4'b1111 constant, all `lock`=0.
  - → grants cycle 0,1,2,3,0, each exactly 4 cycles;
  - one gap cycle between owners, with `timeout`=1 in each gap.
- Lock:
  - `req`=4'b0011, `lock[0]`=1 → owner 0 keeps the grant 20+ cycles with no timeout.
  - clear `lock[0]` → preempt at the next edge; `timeout` pulse, then `gnt`=4'b0010.
- Simultaneous release: owner 1 drops `req` on the same edge that `req[3]` and `req[0]` rise.
  - → one TURN cycle, then `gnt`=4'b1000 (search order 2,3,0).
- Reset mid-OWN: `rst` pulsed while owner 2 holds the bus, `req`=4'b1101.
  - → no-grant cycle(s), no timeout pulse.
  - then `gnt`=4'b0001, because `last` was reset to N-1.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter family: FSM state encodings and default hold limit.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    BA_IDLE = 2'd0,
    BA_OWN  = 2'd1,
    BA_TURN = 2'd2
  } ba_state_e;

  localparam int BA_MAX_HOLD_DEF = 16;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after (last+1) mod N, with wrap.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          any_o,
  output logic [IW-1:0] winner_o
);

  always_comb begin
    int idx;
    any_o    = 1'b0;
    winner_o = '0;
    idx      = 0;
    // Walk the search order backwards so the earliest hit is the final assignment.
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_i) + k) % N;
      if (req_i[idx]) begin
        any_o    = 1'b1;
        winner_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of a shared W-bit bus: bounded hold, owner lock, one-cycle turnaround.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = BA_MAX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         lock,
  input  logic [N*W-1:0]       data_in,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic [W-1:0]         bus_out,
  output logic                 bus_valid,
  output logic                 timeout
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  ba_state_e     state_q;
  logic [N-1:0]  gnt_q;
  logic [IW-1:0] gnt_id_q;
  logic [IW-1:0] last_q;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          timeout_q;

  logic          pick_any;
  logic [IW-1:0] pick_winner;
  logic [N-1:0]  owner_oh;
  logic          others_req;
  logic          at_limit;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .any_o    (pick_any),
    .winner_o (pick_winner)
  );

  // While owning, last_q is the current owner.
  assign owner_oh   = {{(N-1){1'b0}}, 1'b1} << last_q;
  assign others_req = |(req & ~owner_oh);
  assign at_limit   = (hold_q == HW'(MAX_HOLD));
  assign hold_d     = at_limit ? hold_q : hold_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BA_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      last_q    <= IW'(N - 1);
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        BA_IDLE, BA_TURN: begin
          if (pick_any) begin
            state_q  <= BA_OWN;
            gnt_q    <= {{(N-1){1'b0}}, 1'b1} << pick_winner;
            gnt_id_q <= pick_winner;
            last_q   <= pick_winner;
            hold_q   <= HW'(1);
          end else begin
            state_q <= BA_IDLE;
          end
        end
        BA_OWN: begin
          if (!req[last_q]) begin
            state_q  <= BA_TURN;
            gnt_q    <= '0;
            gnt_id_q <= '0;
          end else if (at_limit && !lock[last_q] && others_req) begin
            state_q   <= BA_TURN;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            timeout_q <= 1'b1;
          end else begin
            hold_q <= hold_d;
          end
        end
        default: begin
          state_q  <= BA_IDLE;
          gnt_q    <= '0;
          gnt_id_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus_out = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) bus_out = data_in[i*W +: W];
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign bus_valid = |gnt_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter against an ownership-level reference model.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   gnt;
  logic [1:0]     gnt_id;
  logic [W-1:0]   bus_out;
  logic           bus_valid;
  logic           timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the bus, who owned it last, how long it has held.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_held  = 0;
  bit m_tmo   = 1'b0;

  bus_arbiter #(.N(N), .W(W), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .data_in   (data_in),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int off = 1; off <= N; off++) begin
      if (r[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  function automatic bit others_want(input logic [N-1:0] r, input int owner);
    for (int i = 0; i < N; i++) begin
      if (i != owner && r[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_edge();
    int w;
    if (rst) begin
      m_owner = -1;
      m_last  = N - 1;
      m_held  = 0;
      m_tmo   = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (m_owner >= 0) begin
        if (!req[m_owner]) begin
          m_owner = -1;
        end else if (m_held >= MH && !lock[m_owner] && others_want(req, m_owner)) begin
          m_owner = -1;
          m_tmo   = 1'b1;
        end else begin
          m_held++;
        end
      end else begin
        w = pick(req, m_last);
        if (w >= 0) begin
          m_owner = w;
          m_last  = w;
          m_held  = 1;
        end
      end
    end
  endtask

  task automatic step();
    int eg;
    int eid;
    int ebus;
    @(posedge clk);
    model_edge();
    #1;
    eg   = (m_owner >= 0) ? (1 << m_owner) : 0;
    eid  = (m_owner >= 0) ? m_owner : 0;
    ebus = (m_owner >= 0) ? int'(data_in[m_owner*W +: W]) : 0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("gnt_id", 32'(gnt_id), 32'(eid));
    chk("bus_out", 32'(bus_out), 32'(ebus));
    chk("bus_valid", 32'(bus_valid), 32'(m_owner >= 0));
    chk("timeout", 32'(timeout), 32'(m_tmo));
  endtask

  initial begin
    rst     = 1'b1;
    req     = 4'b1111;
    lock    = '0;
    data_in = 32'h44_33_22_11;

    // Reset held with all requests pending
    step();
    step();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    rst = 1'b0;
    step();
    chk("rst_first_gnt", 32'(gnt), 32'h1);

    // Single requester
    req = 4'b0000;
    step();
    step();
    req     = 4'b0100;
    data_in = 32'h00_A5_00_00;
    step();
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_id", 32'(gnt_id), 32'h2);
    chk("single_bus", 32'(bus_out), 32'hA5);
    req = 4'b0000;
    step();
    chk("single_release", 32'(gnt), 32'h0);
    step();

    // Rotation under full contention
    rst = 1'b1;
    step();
    rst     = 1'b0;
    req     = 4'b1111;
    data_in = 32'hD3_C2_B1_A0;
    for (int i = 0; i < 26; i++) step();

    // Lock holds owner 0 beyond MAX_HOLD, then release of lock preempts
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst  = 1'b0;
    req  = 4'b0011;
    lock = 4'b0001;
    for (int i = 0; i < 22; i++) step();
    chk("lock_hold_gnt", 32'(gnt), 32'h1);
    chk("lock_hold_tmo", 32'(timeout), 32'h0);
    lock = 4'b0000;
    step();
    chk("lock_preempt_tmo", 32'(timeout), 32'h1);
    chk("lock_preempt_gap", 32'(gnt), 32'h0);
    step();
    chk("lock_next_owner", 32'(gnt), 32'h2);

    // Owner 1 releases as requesters 3 and 0 rise
    req = 4'b1001;
    step();
    chk("simul_gap", 32'(gnt), 32'h0);
    step();
    chk("simul_winner", 32'(gnt), 32'h8);

    // Reset while requester 2 owns the bus
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
    req = 4'b0100;
    step();
    chk("midrst_owner2", 32'(gnt), 32'h4);
    req = 4'b1101;
    step();
    rst = 1'b1;
    step();
    chk("midrst_gap", 32'(gnt), 32'h0);
    chk("midrst_tmo", 32'(timeout), 32'h0);
    rst = 1'b0;
    step();
    chk("midrst_restart", 32'(gnt), 32'h1);

    // Randomized traffic with sticky request/lock levels
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(99) == 0);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) req[b] = ~req[b];
        if ($urandom_range(15) == 0) lock[b] = ~lock[b];
      end
      data_in = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
